// File: rtl/cpu_pkg.sv
// Shared CPU encodings: ALU sub-operation select and multiply/divide sequencer states.
package cpu_pkg;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the instruction decoder and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, res_lo, res_hi, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, res_lo, res_hi, div_zero
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide
// over a shared accumulator {upper[WIDTH:0], lower[WIDTH-1:0]}.
module muldiv_step
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  op_e                op,
    input  logic [2*WIDTH:0]   acc,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH:0]   acc_next
);
    logic [WIDTH:0]   hi_sum;
    logic [2*WIDTH:0] shl;
    logic [WIDTH+1:0] diff;

    always_comb begin
        hi_sum = acc[2*WIDTH:WIDTH];
        if (acc[0]) begin
            hi_sum = acc[2*WIDTH:WIDTH] + {1'b0, b};
        end
        // Remainder stays below the divisor, so its MSB is zero before the shift and nothing is lost.
        shl  = {acc[2*WIDTH-1:0], 1'b0};
        diff = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, b};

        acc_next = '0;
        if (op == OP_MUL) begin
            acc_next = {1'b0, hi_sum, acc[WIDTH-1:1]};
        end else if (diff[WIDTH+1]) begin
            acc_next = shl;
        end else begin
            acc_next = {diff[WIDTH:0], shl[WIDTH-1:1], 1'b1};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide controller: one step per clock, results
// registered on completion with a single-cycle done pulse.
module muldiv_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = 2 * WIDTH + 1;

    seq_state_e       state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [AW-1:0]    acc_q, acc_d, acc_step;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op       (op_q),
        .acc      (acc_q),
        .b        (b_q),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dz_d     = dz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = op_e'(bus.op);
                    b_d   = bus.b;
                    cnt_d = '0;
                    if (op_e'(bus.op) == OP_DIV && bus.b == '0) begin
                        state_d  = DONE;
                        res_lo_d = '1;
                        res_hi_d = bus.a;
                        dz_d     = 1'b1;
                    end else begin
                        state_d = RUN;
                        acc_d   = {{(WIDTH+1){1'b0}}, bus.a};
                    end
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                // Final step's output goes straight to the result registers.
                if (cnt_d >= CW'(WIDTH)) begin
                    state_d  = DONE;
                    res_lo_d = acc_step[WIDTH-1:0];
                    res_hi_d = acc_step[2*WIDTH-1:WIDTH];
                    dz_d     = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.res_lo   = res_lo_q;
    assign bus.res_hi   = res_hi_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, protocol corner cases,
// and random operations against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(8)) bus ();

    muldiv_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       dz;
        int         edges;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {div_zero, hi, lo} from plain arithmetic.
    function automatic logic [16:0] model(input logic op, input logic [7:0] a, input logic [7:0] b);
        int p;
        if (!op) begin
            p = int'(a) * int'(b);
            return {1'b0, p[15:0]};
        end
        if (b == 8'd0) return {1'b1, a, 8'hFF};
        return {1'b0, 8'(a % b), 8'(a / b)};
    endfunction

    // Called #1 after a posedge with the DUT idle; returns #1 after the edge where done is seen.
    task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                          output logic [16:0] res, output int edges);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 1;
        while (!bus.done && edges < 40) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            @(posedge clk); #1;
            edges++;
        end
        res = {bus.div_zero, bus.res_hi, bus.res_lo};
    endtask

    task automatic apply(input string name, input logic op, input logic [7:0] a, input logic [7:0] b,
                         input logic [16:0] exp, input int exp_edges);
        logic [16:0] res;
        int          edges;
        run_op(op, a, b, res, edges);
        check({name, " latency"}, 32'(edges), 32'(exp_edges));
        check({name, " result"}, 32'(res), 32'(exp));
        @(posedge clk); #1;
        check({name, " done pulse"}, 32'(bus.done), 32'd0);
        check({name, " hold"}, 32'({bus.div_zero, bus.res_hi, bus.res_lo}), 32'(res));
    endtask

    initial begin
        logic [16:0] res;
        logic [16:0] exp;
        int          edges;
        int          dones;
        logic        op;
        logic [7:0]  a;
        logic [7:0]  b;

        tbl[0] = '{1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 9};
        tbl[1] = '{1'b0, 8'hFF,  8'hFF,  8'hFE, 8'h01, 1'b0, 9};
        tbl[2] = '{1'b0, 8'h00,  8'h5A,  8'h00, 8'h00, 1'b0, 9};
        tbl[3] = '{1'b1, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 9};
        tbl[4] = '{1'b1, 8'd5,   8'd9,   8'h05, 8'h00, 1'b0, 9};
        tbl[5] = '{1'b1, 8'h42,  8'h00,  8'h42, 8'hFF, 1'b1, 1};
        tbl[6] = '{1'b0, 8'd2,   8'd3,   8'h00, 8'h06, 1'b0, 9};

        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset results", 32'({bus.div_zero, bus.res_hi, bus.res_lo}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            apply($sformatf("table[%0d]", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  {tbl[i].dz, tbl[i].hi, tbl[i].lo}, tbl[i].edges);
        end

        // start re-asserted mid-RUN with a divide-by-zero request must be ignored
        bus.op = 1'b0; bus.a = 8'd13; bus.b = 8'd11; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 1;
        repeat (3) begin @(posedge clk); #1; edges++; end
        check("mid-run busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 8'h99; bus.b = 8'h00;
        @(posedge clk); #1;
        edges++;
        bus.start = 1'b0;
        while (!bus.done && edges < 40) begin @(posedge clk); #1; edges++; end
        check("ignored start latency", 32'(edges), 32'd9);
        check("ignored start result", 32'({bus.div_zero, bus.res_hi, bus.res_lo}), 32'h0008F);
        @(posedge clk); #1;
        check("ignored start idle", 32'(bus.busy), 32'd0);

        // start held high through DONE: next op accepted on the edge after DONE->IDLE
        bus.op = 1'b0; bus.a = 8'd2; bus.b = 8'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        while (!bus.done && edges < 40) begin @(posedge clk); #1; edges++; end
        check("b2b first latency", 32'(edges), 32'd9);
        check("b2b first result", 32'({bus.div_zero, bus.res_hi, bus.res_lo}), 32'h00006);
        bus.op = 1'b1; bus.a = 8'd200; bus.b = 8'd7;
        @(posedge clk); #1;
        check("b2b idle gap busy", 32'(bus.busy), 32'd0);
        check("b2b idle gap done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        check("b2b second accepted", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        edges = 1;
        while (!bus.done && edges < 40) begin @(posedge clk); #1; edges++; end
        check("b2b second latency", 32'(edges), 32'd9);
        check("b2b second result", 32'({bus.div_zero, bus.res_hi, bus.res_lo}), 32'h0041C);
        @(posedge clk); #1;

        // reset on the 4th iteration aborts silently and clears results
        bus.op = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort results", 32'({bus.div_zero, bus.res_hi, bus.res_lo}), 32'd0);
        dones = 0;
        repeat (12) begin @(posedge clk); #1; if (bus.done) dones++; end
        check("abort no done", 32'(dones), 32'd0);
        apply("after abort", 1'b0, 8'd13, 8'd11, 17'h0008F, 9);

        for (int i = 0; i < 200; i++) begin
            op = 1'($urandom);
            a  = 8'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            exp = model(op, a, b);
            run_op(op, a, b, res, edges);
            check($sformatf("rand[%0d] op=%0d a=%0h b=%0h latency", i, op, a, b),
                  32'(edges), exp[16] ? 32'd1 : 32'd9);
            check($sformatf("rand[%0d] op=%0d a=%0h b=%0h result", i, op, a, b),
                  32'(res), 32'(exp));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
